// File: rtl/debouncer_bank.sv
// N-channel push-button conditioner: input synchroniser, stability-count debounce,
// press/release pulses and per-channel auto-repeat. Every output is a flop.
module debouncer_bank #(
   parameter int N_CH          = 4,
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 1_000_000,
   parameter int CNT_W         = 20,
   parameter int REPEAT_DELAY  = 50_000_000,
   parameter int REPEAT_RATE   = 10_000_000,
   parameter int RPT_W         = 26
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N_CH-1:0] btn_in,
   input  logic [N_CH-1:0] repeat_en,
   output logic [N_CH-1:0] level_out,
   output logic [N_CH-1:0] press_pulse,
   output logic [N_CH-1:0] release_pulse,
   output logic            any_pressed
);
   typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

   localparam logic [CNT_W-1:0] DC_LAST    = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

   logic [N_CH-1:0]  r_sync [SYNC_STAGES];
   logic [N_CH-1:0]  r_samp;
   logic [CNT_W-1:0] r_dc [N_CH];
   logic [CNT_W-1:0] w_dc_nxt [N_CH];
   logic [N_CH-1:0]  r_level, w_level_nxt, w_rise, w_fall;
   state_t           r_state [N_CH];
   state_t           w_state_nxt [N_CH];
   logic [RPT_W-1:0] r_rc [N_CH];
   logic [RPT_W-1:0] w_rc_nxt [N_CH];
   logic [N_CH-1:0]  r_press, r_release, w_press_nxt, w_release_nxt;
   logic             r_any;

   // The sample flop after the synchroniser puts the level flip exactly
   // SYNC_STAGES+STABLE_CYCLES edges after the first edge that saw the new level.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
         r_samp <= '0;
      end else begin
         // NOTE: non-blocking assignments let every flop sample the pre-edge
         // value of its neighbour, which is what makes the chain a shift register.
         r_sync[0] <= btn_in;
         for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
         r_samp <= r_sync[SYNC_STAGES-1];
      end
   end

   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no
      // path through the branches leaves it unassigned (that would infer a latch).
      w_level_nxt = r_level;
      for (int i = 0; i < N_CH; i++) begin
         w_dc_nxt[i] = '0;
         if (r_samp[i] != r_level[i]) begin
            if (r_dc[i] == DC_LAST) w_level_nxt[i] = r_samp[i];
            else                    w_dc_nxt[i]    = r_dc[i] + 1'b1;
         end
      end
   end

   assign w_rise = w_level_nxt & ~r_level;
   assign w_fall = ~w_level_nxt & r_level;

   always_comb begin
      w_press_nxt   = '0;
      w_release_nxt = '0;
      for (int i = 0; i < N_CH; i++) begin
         w_state_nxt[i] = r_state[i];
         w_rc_nxt[i]    = '0;
         case (r_state[i])
            IDLE: begin
               if (w_rise[i]) begin
                  w_press_nxt[i] = 1'b1;
                  w_state_nxt[i] = HOLD;
               end
            end
            HOLD, REPEAT: begin
               // A release wins over a repeat pulse falling due on the same edge.
               if (w_fall[i]) begin
                  w_release_nxt[i] = 1'b1;
                  w_state_nxt[i]   = IDLE;
               end else if (repeat_en[i]) begin
                  if ((r_state[i] == HOLD) ? (r_rc[i] == DELAY_LAST) : (r_rc[i] == RATE_LAST)) begin
                     w_press_nxt[i] = 1'b1;
                     w_state_nxt[i] = REPEAT;
                  end else begin
                     w_rc_nxt[i] = r_rc[i] + 1'b1;
                  end
               end
            end
            default: w_state_nxt[i] = IDLE;
         endcase
      end
   end

   // NOTE: the per-channel counter arrays are ordinary flops, not RAM, so they
   // take the asynchronous reset like every other register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N_CH; i++) begin
            r_dc[i]    <= '0;
            r_rc[i]    <= '0;
            r_state[i] <= IDLE;
         end
         r_level   <= '0;
         r_press   <= '0;
         r_release <= '0;
         r_any     <= 1'b0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            r_dc[i]    <= w_dc_nxt[i];
            r_rc[i]    <= w_rc_nxt[i];
            r_state[i] <= w_state_nxt[i];
         end
         r_level   <= w_level_nxt;
         r_press   <= w_press_nxt;
         r_release <= w_release_nxt;
         r_any     <= |w_level_nxt;
      end
   end

   assign level_out     = r_level;
   assign press_pulse   = r_press;
   assign release_pulse = r_release;
   assign any_pressed   = r_any;

endmodule

// File: tb/tb_debouncer_bank.sv
// Bench for debouncer_bank: directed scenarios plus random button traffic, every
// edge compared against an edge-indexed behavioural model of the button rules.
module tb_debouncer_bank;
   localparam int N      = 4;
   localparam int SYNC   = 2;
   localparam int STABLE = 4;
   localparam int DELAY  = 10;
   localparam int RATE   = 3;
   localparam int LAT    = SYNC + STABLE;
   localparam int MAXE   = 4096;

   logic         clk       = 1'b0;
   logic         reset     = 1'b0;
   logic [N-1:0] btn_in    = '0;
   logic [N-1:0] repeat_en = '0;
   logic [N-1:0] level_out, press_pulse, release_pulse;
   logic         any_pressed;

   debouncer_bank #(
      .N_CH(N), .SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE), .CNT_W(3),
      .REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE), .RPT_W(4)
   ) dut (
      .clk(clk), .reset(reset), .btn_in(btn_in), .repeat_en(repeat_en),
      .level_out(level_out), .press_pulse(press_pulse),
      .release_pulse(release_pulse), .any_pressed(any_pressed)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   // Model: raw sample seen at each edge, current level, edge of last flip,
   // and the edge from which the next repeat interval is measured.
   bit           hist [N][MAXE];
   bit           m_lvl [N];
   int           m_flip [N];
   int           m_anchor [N];
   bit           m_first [N];
   logic [N-1:0] e_press, e_release;

   int press_cnt [N];
   int rel_cnt [N];
   int lpe [N];
   int lre [N];
   int q0[$];
   int q1[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 'h%0h required 'h%0h (edge %0d)", tag, obs, exp, cyc);
   endtask

   task automatic model_clear();
      for (int i = 0; i < N; i++) begin
         m_lvl[i] = 1'b0; m_flip[i] = -100; m_anchor[i] = 0; m_first[i] = 1'b0;
      end
      e_press = '0; e_release = '0;
   endtask

   // Level flips when STABLE consecutive samples, taken LAT..LAT-STABLE+1 edges
   // back and all newer than the previous flip's window, differ from it.
   task automatic model_edge();
      for (int i = 0; i < N; i++) begin
         bit flipped;
         flipped = 1'b0;
         e_press[i] = 1'b0; e_release[i] = 1'b0;
         if (!reset) begin
            if (cyc < MAXE) hist[i][cyc] = 1'b0;
         end else begin
            if (cyc < MAXE) hist[i][cyc] = btn_in[i];
            if (cyc >= LAT && cyc < MAXE && cyc >= m_flip[i] + STABLE) begin
               bit differs;
               differs = 1'b1;
               for (int k = LAT - STABLE + 1; k <= LAT; k++)
                  if (hist[i][cyc-k] == m_lvl[i]) differs = 1'b0;
               if (differs) begin
                  flipped = 1'b1;
                  m_lvl[i] = ~m_lvl[i];
                  m_flip[i] = cyc;
                  if (m_lvl[i]) begin
                     e_press[i] = 1'b1; m_anchor[i] = cyc; m_first[i] = 1'b1;
                  end else begin
                     e_release[i] = 1'b1;
                  end
               end
            end
            if (!flipped && m_lvl[i]) begin
               if (!repeat_en[i]) m_anchor[i] = cyc;
               else if (cyc - m_anchor[i] == (m_first[i] ? DELAY : RATE)) begin
                  e_press[i] = 1'b1; m_anchor[i] = cyc; m_first[i] = 1'b0;
               end
            end
         end
      end
   endtask

   task automatic compare_all();
      logic [N-1:0] e_lvl;
      for (int i = 0; i < N; i++) e_lvl[i] = m_lvl[i];
      check("level_out", level_out, e_lvl);
      check("press_pulse", press_pulse, e_press);
      check("release_pulse", release_pulse, e_release);
      check("any_pressed", any_pressed, |e_lvl);
   endtask

   task automatic clear_counts();
      for (int i = 0; i < N; i++) begin
         press_cnt[i] = 0; rel_cnt[i] = 0; lpe[i] = -1; lre[i] = -1;
      end
      q0.delete(); q1.delete();
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      model_edge();
      #1;
      compare_all();
      for (int i = 0; i < N; i++) begin
         if (press_pulse[i] === 1'b1) begin
            press_cnt[i]++; lpe[i] = cyc;
            if (i == 0) q0.push_back(cyc);
            if (i == 1) q1.push_back(cyc);
         end
         if (release_pulse[i] === 1'b1) begin
            rel_cnt[i]++; lre[i] = cyc;
         end
      end
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   initial begin
      int s;
      int late;
      model_clear();
      clear_counts();

      // Reset state
      run(3);
      check("rst_level", level_out, 4'h0);
      check("rst_any", any_pressed, 1'b0);
      reset = 1'b1;
      run(5);

      // 1 Clean press on ch0
      clear_counts();
      btn_in[0] = 1'b1; s = cyc + 1;
      run(LAT + 4);
      check("t1_press_cnt", press_cnt[0], 1);
      check("t1_press_edge", lpe[0], s + LAT);
      check("t1_others_level", level_out[3:1], 3'b000);
      check("t1_any", any_pressed, 1'b1);
      btn_in[0] = 1'b0; s = cyc + 1;
      run(LAT + 4);
      check("t1_release_edge", lre[0], s + LAT);

      // 2 Bounce on ch2
      clear_counts();
      for (int b = 0; b < 4; b++) begin
         btn_in[2] = (b % 2 == 0);
         run(2);
      end
      btn_in[2] = 1'b1; s = cyc + 1;
      run(LAT + 6);
      check("t2_press_cnt", press_cnt[2], 1);
      check("t2_press_edge", lpe[2], s + LAT);
      btn_in[2] = 1'b0;
      run(LAT + 2);

      // 3 Auto-repeat on ch1
      clear_counts();
      repeat_en[1] = 1'b1; btn_in[1] = 1'b1; s = cyc + 1;
      run(LAT + 18);
      check("t3_rpt0", q1[0], s + LAT);
      check("t3_rpt1", q1[1], s + LAT + DELAY);
      check("t3_rpt2", q1[2], s + LAT + DELAY + RATE);
      check("t3_rpt3", q1[3], s + LAT + DELAY + 2 * RATE);
      btn_in[1] = 1'b0; s = cyc + 1;
      run(LAT + 20);
      check("t3_release_cnt", rel_cnt[1], 1);
      check("t3_release_edge", lre[1], s + LAT);
      late = 0;
      foreach (q1[k]) if (q1[k] >= lre[1]) late++;
      check("t3_no_press_after_release", late, 0);
      repeat_en[1] = 1'b0;

      // 4 Repeat disabled on ch3
      clear_counts();
      repeat_en[3] = 1'b0; btn_in[3] = 1'b1;
      run(100);
      check("t4_press_cnt", press_cnt[3], 1);
      btn_in[3] = 1'b0;
      run(LAT + 4);
      check("t4_release_cnt", rel_cnt[3], 1);

      // 5 Simultaneous press on ch1 and ch3, release ch1 only
      clear_counts();
      btn_in[1] = 1'b1; btn_in[3] = 1'b1; s = cyc + 1;
      run(LAT + 4);
      check("t5_press_ch1", lpe[1], s + LAT);
      check("t5_press_ch3", lpe[3], s + LAT);
      btn_in[1] = 1'b0;
      run(LAT + 4);
      check("t5_release_ch1", rel_cnt[1], 1);
      check("t5_level_ch3", level_out[3], 1'b1);
      check("t5_any", any_pressed, 1'b1);
      btn_in[3] = 1'b0;
      run(LAT + 4);

      // 6 Asynchronous reset in the middle of REPEAT on ch0
      clear_counts();
      repeat_en[0] = 1'b1; btn_in[0] = 1'b1;
      run(LAT + DELAY + 2 * RATE + 1);
      check("t6_pre_level", level_out[0], 1'b1);
      #2;
      reset = 1'b0;
      for (int i = 0; i < N; i++)
         for (int k = 0; k < 3; k++)
            if (cyc - k >= 0) hist[i][cyc-k] = 1'b0;
      model_clear();
      #1;
      compare_all();
      check("t6_async_level", level_out, 4'h0);
      check("t6_async_press", press_pulse, 4'h0);
      run(3);
      reset = 1'b1; clear_counts(); s = cyc + 1;
      run(LAT + DELAY + 4);
      check("t6_repress", q0[0], s + LAT);
      check("t6_repeat", q0[1], s + LAT + DELAY);
      btn_in[0] = 1'b0; repeat_en[0] = 1'b0;
      run(LAT + 4);

      // Random button traffic with bounces and repeat_en changes
      for (int n = 0; n < 800; n++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 11) == 0) btn_in[i] = ~btn_in[i];
            if ($urandom_range(0, 39) == 0) repeat_en[i] = ~repeat_en[i];
         end
         step();
      end
      btn_in = '0;
      run(LAT + 6);
      check("end_level", level_out, 4'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
